// File: rtl/lsb_ring.sv
// Circular load/store buffer: holds memory ops in program order, snoops result
// buses, issues the head op to the data cache and broadcasts load results.

module lsb_entry #(
  parameter int ROB_W = 4,
  parameter int CDB_N = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   flush,
  input  logic                   wr,
  input  logic                   clr,
  input  logic                   wr_store,
  input  logic [5:0]             wr_op,
  input  logic [ROB_W-1:0]       wr_rob,
  input  logic [31:0]            wr_base,
  input  logic                   wr_base_rdy,
  input  logic [31:0]            wr_imm,
  input  logic [31:0]            wr_data,
  input  logic                   wr_data_rdy,
  input  logic [CDB_N-1:0]       cdb_valid,
  input  logic [CDB_N*ROB_W-1:0] cdb_rob,
  input  logic [CDB_N*32-1:0]    cdb_data,
  input  logic                   cm_valid,
  input  logic [ROB_W-1:0]       cm_rob,
  output logic                   valid,
  output logic                   store,
  output logic                   committed,
  output logic [5:0]             op,
  output logic [ROB_W-1:0]       rob,
  output logic [31:0]            base,
  output logic                   base_rdy,
  output logic [31:0]            imm,
  output logic [31:0]            data,
  output logic                   data_rdy
);
  logic [31:0] base_c, data_c, base_cdb, data_cdb;
  logic        base_rdy_c, data_rdy_c, base_hit, data_hit;

  // Snoop operates on the incoming dispatch values too, giving the same-cycle bypass.
  always_comb begin
    base_c     = wr ? wr_base : base;
    base_rdy_c = wr ? wr_base_rdy : base_rdy;
    data_c     = wr ? wr_data : data;
    data_rdy_c = wr ? (wr_data_rdy || !wr_store) : data_rdy;
    base_hit   = 1'b0;
    data_hit   = 1'b0;
    base_cdb   = '0;
    data_cdb   = '0;
    // Walk buses high to low so the lowest matching bus is the one that sticks.
    for (int k = CDB_N - 1; k >= 0; k--) begin
      if (cdb_valid[k] && cdb_rob[k*ROB_W +: ROB_W] == base_c[ROB_W-1:0]) begin
        base_hit = 1'b1;
        base_cdb = cdb_data[k*32 +: 32];
      end
      if (cdb_valid[k] && cdb_rob[k*ROB_W +: ROB_W] == data_c[ROB_W-1:0]) begin
        data_hit = 1'b1;
        data_cdb = cdb_data[k*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= 1'b0;
      store     <= 1'b0;
      committed <= 1'b0;
      op        <= '0;
      rob       <= '0;
      base      <= '0;
      base_rdy  <= 1'b0;
      imm       <= '0;
      data      <= '0;
      data_rdy  <= 1'b0;
    end else if (rdy) begin
      if (clr || (flush && !committed)) begin
        valid     <= 1'b0;
        committed <= 1'b0;
      end else if (!flush) begin
        if (wr) begin
          valid     <= 1'b1;
          store     <= wr_store;
          committed <= 1'b0;
          op        <= wr_op;
          rob       <= wr_rob;
          imm       <= wr_imm;
        end else if (valid && store && cm_valid && rob == cm_rob) begin
          committed <= 1'b1;
        end
        if (wr || valid) begin
          base     <= (!base_rdy_c && base_hit) ? base_cdb : base_c;
          base_rdy <= base_rdy_c || base_hit;
          data     <= (!data_rdy_c && data_hit) ? data_cdb : data_c;
          data_rdy <= data_rdy_c || data_hit;
        end
      end
    end
  end
endmodule

module lsb_ring #(
  parameter int LSB_W = 4,
  parameter int ROB_W = 4,
  parameter int CDB_N = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   is_valid,
  input  logic                   is_store,
  input  logic [5:0]             is_op,
  input  logic [ROB_W-1:0]       is_rob,
  input  logic [31:0]            is_base,
  input  logic                   is_base_rdy,
  input  logic [31:0]            is_imm,
  input  logic [31:0]            is_data,
  input  logic                   is_data_rdy,
  output logic                   full,
  output logic [LSB_W:0]         count,
  input  logic [CDB_N-1:0]       cdb_valid,
  input  logic [CDB_N*ROB_W-1:0] cdb_rob,
  input  logic [CDB_N*32-1:0]    cdb_data,
  input  logic                   cm_valid,
  input  logic [ROB_W-1:0]       cm_rob,
  input  logic                   flush,
  output logic                   mem_req,
  output logic                   mem_store,
  output logic [5:0]             mem_op,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_done,
  input  logic [31:0]            mem_rdata,
  output logic                   ld_valid,
  output logic [ROB_W-1:0]       ld_rob,
  output logic [31:0]            ld_data
);
  localparam int DEPTH = 1 << LSB_W;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef struct packed {
    logic        req;
    logic        store;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] rob;
    logic [31:0]      data;
  } ld_rsp_t;

  logic [DEPTH-1:0]             e_valid, e_store, e_committed, e_base_rdy, e_data_rdy;
  logic [DEPTH-1:0][5:0]        e_op;
  logic [DEPTH-1:0][ROB_W-1:0]  e_rob;
  logic [DEPTH-1:0][31:0]       e_base, e_imm, e_data;

  logic [LSB_W-1:0] head, tail;
  logic [1:0]       state;
  logic [LSB_W:0]   ccount;
  logic             push, pop, go;
  mem_req_t         mreq;
  ld_rsp_t          lrsp;

  assign full  = (count == (LSB_W+1)'(DEPTH));
  assign push  = is_valid && !full && !flush;
  assign pop   = (state == S_BUSY) && mem_done;
  // A head load is discarded by a flush, so it must not launch in that cycle.
  assign go    = (state == S_IDLE) && e_valid[head] &&
                 (e_store[head] ? (e_base_rdy[head] && e_data_rdy[head] && e_committed[head])
                                : (e_base_rdy[head] && !flush));

  always_comb begin
    ccount = '0;
    for (int i = 0; i < DEPTH; i++)
      ccount = ccount + {{LSB_W{1'b0}}, e_valid[i] && e_committed[i]};
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    lsb_entry #(.ROB_W(ROB_W), .CDB_N(CDB_N)) u_ent (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .flush      (flush),
      .wr         (push && tail == LSB_W'(i)),
      .clr        (pop && head == LSB_W'(i)),
      .wr_store   (is_store),
      .wr_op      (is_op),
      .wr_rob     (is_rob),
      .wr_base    (is_base),
      .wr_base_rdy(is_base_rdy),
      .wr_imm     (is_imm),
      .wr_data    (is_data),
      .wr_data_rdy(is_data_rdy),
      .cdb_valid  (cdb_valid),
      .cdb_rob    (cdb_rob),
      .cdb_data   (cdb_data),
      .cm_valid   (cm_valid),
      .cm_rob     (cm_rob),
      .valid      (e_valid[i]),
      .store      (e_store[i]),
      .committed  (e_committed[i]),
      .op         (e_op[i]),
      .rob        (e_rob[i]),
      .base       (e_base[i]),
      .base_rdy   (e_base_rdy[i]),
      .imm        (e_imm[i]),
      .data       (e_data[i]),
      .data_rdy   (e_data_rdy[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      mreq  <= '0;
      lrsp  <= '0;
    end else if (rdy) begin
      lrsp.valid <= 1'b0;
      case (state)
        S_IDLE: if (go) begin
          state      <= S_BUSY;
          mreq.req   <= 1'b1;
          mreq.store <= e_store[head];
          mreq.op    <= e_op[head];
          mreq.addr  <= e_base[head] + e_imm[head];
          mreq.wdata <= e_data[head];
        end
        S_BUSY: if (mem_done) begin
          state      <= S_IDLE;
          mreq.req   <= 1'b0;
          lrsp.valid <= !e_store[head];
          lrsp.rob   <= e_rob[head];
          lrsp.data  <= mem_rdata;
        end else if (flush && !e_store[head]) begin
          state <= S_DRAIN;
        end
        S_DRAIN: if (mem_done) begin
          state    <= S_IDLE;
          mreq.req <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      // Surviving entries are the committed prefix, so the tail snaps to head+ccount.
      if (flush) begin
        head  <= head + LSB_W'(pop);
        tail  <= head + ccount[LSB_W-1:0];
        count <= ccount - {{LSB_W{1'b0}}, pop && e_committed[head]};
      end else begin
        head  <= head + LSB_W'(pop);
        tail  <= tail + LSB_W'(push);
        count <= count + {{LSB_W{1'b0}}, push} - {{LSB_W{1'b0}}, pop};
      end
    end
  end

  assign mem_req   = mreq.req;
  assign mem_store = mreq.store;
  assign mem_op    = mreq.op;
  assign mem_addr  = mreq.addr;
  assign mem_wdata = mreq.wdata;
  assign ld_valid  = lrsp.valid;
  assign ld_rob    = lrsp.rob;
  assign ld_data   = lrsp.data;
endmodule

// File: tb/tb_lsb_ring.sv
// Scenario bench for lsb_ring: expected requests and load results are queued on
// stimulus and popped when the cache port / result bus shows them.

module tb_lsb_ring;
  localparam int LSB_W = 4;
  localparam int ROB_W = 4;
  localparam int CDB_N = 2;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        is_valid, is_store, is_base_rdy, is_data_rdy;
  logic [5:0]  is_op;
  logic [3:0]  is_rob;
  logic [31:0] is_base, is_imm, is_data;
  logic        full;
  logic [4:0]  count;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob;
  logic [63:0] cdb_data;
  logic        cm_valid, flush;
  logic [3:0]  cm_rob;
  logic        mem_req, mem_store, mem_done, ld_valid;
  logic [5:0]  mem_op;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, ld_data;
  logic [3:0]  ld_rob;

  typedef struct packed { logic st; logic [5:0] op; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct packed { logic [3:0] rob; logic [31:0] data; } ld_t;
  req_t exp_req[$];
  ld_t  exp_ld[$];
  req_t r;
  ld_t  l;
  int   checks = 0;
  int   errors = 0;
  bit   ok;

  lsb_ring #(.LSB_W(LSB_W), .ROB_W(ROB_W), .CDB_N(CDB_N)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .is_valid(is_valid), .is_store(is_store), .is_op(is_op), .is_rob(is_rob),
    .is_base(is_base), .is_base_rdy(is_base_rdy), .is_imm(is_imm),
    .is_data(is_data), .is_data_rdy(is_data_rdy),
    .full(full), .count(count),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
    .cm_valid(cm_valid), .cm_rob(cm_rob), .flush(flush),
    .mem_req(mem_req), .mem_store(mem_store), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_rob(ld_rob), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic dispatch(input logic st, input logic [5:0] op, input logic [3:0] rob,
                          input logic [31:0] base, input logic brdy, input logic [31:0] imm,
                          input logic [31:0] data, input logic drdy);
    is_valid = 1'b1; is_store = st; is_op = op; is_rob = rob;
    is_base = base; is_base_rdy = brdy; is_imm = imm; is_data = data; is_data_rdy = drdy;
    tick();
    is_valid = 1'b0;
  endtask

  task automatic wait_req(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) begin found = 1'b1; return; end
      tick();
    end
  endtask

  task automatic done_pulse(input logic [31:0] rdata);
    mem_done = 1'b1; mem_rdata = rdata;
    tick();
    mem_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({mem_req, ld_valid, full, count, mem_addr, mem_wdata, ld_data} !== '0) begin
      errors++; $display("FAIL reset: req=%b ldv=%b full=%b count=%0d addr=%h want all 0",
                         mem_req, ld_valid, full, count, mem_addr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load();
    dispatch(1'b0, 6'h02, 4'd3, 32'h1000, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0);
    exp_req.push_back('{1'b0, 6'h02, 32'h0FFC, 32'h0});
    checks++;
    if (count !== 5'd1) begin errors++; $display("FAIL load_count: got %0d want 1", count); end
    wait_req(ok);
    r = exp_req.pop_front(); checks++;
    if (!ok || mem_store !== r.st || mem_op !== r.op || mem_addr !== r.addr) begin
      errors++; $display("FAIL load_req: req=%b st=%b op=%h addr=%h want st=%b op=%h addr=%h",
                         mem_req, mem_store, mem_op, mem_addr, r.st, r.op, r.addr);
    end
    exp_ld.push_back('{4'd3, 32'hDEAD_BEEF});
    done_pulse(32'hDEAD_BEEF);
    l = exp_ld.pop_front(); checks++;
    if (ld_valid !== 1'b1 || ld_rob !== l.rob || ld_data !== l.data || count !== 5'd0) begin
      errors++; $display("FAIL load_result: v=%b rob=%0d data=%h count=%0d want v=1 rob=%0d data=%h count=0",
                         ld_valid, ld_rob, ld_data, count, l.rob, l.data);
    end
    tick(); checks++;
    if (ld_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL load_pulse: ldv=%b req=%b want 0 0", ld_valid, mem_req);
    end
  endtask

  task automatic test_store_commit();
    dispatch(1'b1, 6'h23, 4'd5, 32'h2000, 1'b1, 32'd8, 32'd2, 1'b0);
    tick(); tick(); checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL store_wait_data: req=%b want 0", mem_req); end
    cdb_valid = 2'b10; cdb_rob = {4'd2, 4'd0}; cdb_data = {32'h55, 32'h0};
    tick();
    cdb_valid = 2'b00;
    tick(); tick(); checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL store_wait_commit: req=%b want 0", mem_req); end
    cm_valid = 1'b1; cm_rob = 4'd5;
    exp_req.push_back('{1'b1, 6'h23, 32'h2008, 32'h55});
    tick();
    cm_valid = 1'b0;
    wait_req(ok);
    r = exp_req.pop_front(); checks++;
    if (!ok || mem_store !== r.st || mem_op !== r.op || mem_addr !== r.addr || mem_wdata !== r.wdata) begin
      errors++; $display("FAIL store_req: req=%b st=%b addr=%h wdata=%h want st=1 addr=%h wdata=%h",
                         mem_req, mem_store, mem_addr, mem_wdata, r.addr, r.wdata);
    end
    done_pulse(32'h0); checks++;
    if (ld_valid !== 1'b0 || count !== 5'd0) begin
      errors++; $display("FAIL store_done: ldv=%b count=%0d want 0 0", ld_valid, count);
    end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 16; i++)
      dispatch(1'b1, 6'h23, 4'(i), 32'h8000 + 32'(i * 16), 1'b1, 32'h0, 32'(i), 1'b1);
    checks++;
    if (full !== 1'b1 || count !== 5'd16) begin
      errors++; $display("FAIL full_set: full=%b count=%0d want 1 16", full, count);
    end
    dispatch(1'b0, 6'h02, 4'd9, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    checks++;
    if (count !== 5'd16 || mem_req !== 1'b0) begin
      errors++; $display("FAIL full_drop: count=%0d req=%b want 16 0", count, mem_req);
    end
    cm_valid = 1'b1; cm_rob = 4'd0;
    exp_req.push_back('{1'b1, 6'h23, 32'h8000, 32'h0});
    tick();
    cm_valid = 1'b0;
    wait_req(ok);
    r = exp_req.pop_front(); checks++;
    if (!ok || mem_store !== r.st || mem_addr !== r.addr || mem_wdata !== r.wdata) begin
      errors++; $display("FAIL full_head_req: req=%b addr=%h wdata=%h want addr=%h wdata=%h",
                         mem_req, mem_addr, mem_wdata, r.addr, r.wdata);
    end
    done_pulse(32'h0); checks++;
    if (full !== 1'b0 || count !== 5'd15) begin
      errors++; $display("FAIL full_pop: full=%b count=%0d want 0 15", full, count);
    end
    dispatch(1'b1, 6'h23, 4'd0, 32'h9000, 1'b1, 32'h0, 32'h1, 1'b1);
    checks++;
    if (full !== 1'b1 || count !== 5'd16) begin
      errors++; $display("FAIL full_refill: full=%b count=%0d want 1 16", full, count);
    end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++;
    if (count !== 5'd0 || full !== 1'b0) begin
      errors++; $display("FAIL full_flush: count=%0d full=%b want 0 0", count, full);
    end
  endtask

  task automatic test_flush_commit();
    dispatch(1'b1, 6'h23, 4'd1, 32'h3000, 1'b1, 32'd4, 32'h11, 1'b1);
    dispatch(1'b1, 6'h23, 4'd2, 32'h3100, 1'b1, 32'd0, 32'h22, 1'b1);
    dispatch(1'b0, 6'h02, 4'd3, 32'h3200, 1'b1, 32'd0, 32'h0, 1'b0);
    dispatch(1'b0, 6'h02, 4'd4, 32'h3300, 1'b1, 32'd0, 32'h0, 1'b0);
    cm_valid = 1'b1; cm_rob = 4'd1;
    exp_req.push_back('{1'b1, 6'h23, 32'h3004, 32'h11});
    tick();
    cm_valid = 1'b0;
    wait_req(ok);
    r = exp_req.pop_front(); checks++;
    if (!ok || mem_store !== r.st || mem_addr !== r.addr || mem_wdata !== r.wdata) begin
      errors++; $display("FAIL flushc_req: req=%b addr=%h wdata=%h want addr=%h wdata=%h",
                         mem_req, mem_addr, mem_wdata, r.addr, r.wdata);
    end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++;
    if (count !== 5'd1 || mem_req !== 1'b1) begin
      errors++; $display("FAIL flushc_keep: count=%0d req=%b want 1 1", count, mem_req);
    end
    done_pulse(32'h0); checks++;
    if (count !== 5'd0 || ld_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL flushc_done: count=%0d ldv=%b req=%b want 0 0 0", count, ld_valid, mem_req);
    end
    tick(); tick(); tick(); checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL flushc_gone: req=%b want 0", mem_req); end
  endtask

  task automatic test_drain();
    dispatch(1'b0, 6'h02, 4'd7, 32'h4000, 1'b1, 32'd0, 32'h0, 1'b0);
    exp_req.push_back('{1'b0, 6'h02, 32'h4000, 32'h0});
    wait_req(ok);
    r = exp_req.pop_front(); checks++;
    if (!ok || mem_addr !== r.addr) begin
      errors++; $display("FAIL drain_req: req=%b addr=%h want addr=%h", mem_req, mem_addr, r.addr);
    end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++;
    if (count !== 5'd0 || mem_req !== 1'b1) begin
      errors++; $display("FAIL drain_enter: count=%0d req=%b want 0 1", count, mem_req);
    end
    dispatch(1'b0, 6'h03, 4'd8, 32'h5000, 1'b1, 32'd0, 32'h0, 1'b0);
    exp_req.push_back('{1'b0, 6'h03, 32'h5000, 32'h0});
    tick(); tick(); checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h4000) begin
      errors++; $display("FAIL drain_hold: req=%b addr=%h want 1 00004000", mem_req, mem_addr);
    end
    done_pulse(32'h1234); checks++;
    if (ld_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL drain_swallow: ldv=%b req=%b want 0 0", ld_valid, mem_req);
    end
    wait_req(ok);
    r = exp_req.pop_front(); checks++;
    if (!ok || mem_op !== r.op || mem_addr !== r.addr) begin
      errors++; $display("FAIL drain_next_req: req=%b op=%h addr=%h want op=%h addr=%h",
                         mem_req, mem_op, mem_addr, r.op, r.addr);
    end
    exp_ld.push_back('{4'd8, 32'h77});
    done_pulse(32'h77);
    l = exp_ld.pop_front(); checks++;
    if (ld_valid !== 1'b1 || ld_rob !== l.rob || ld_data !== l.data) begin
      errors++; $display("FAIL drain_next_ld: v=%b rob=%0d data=%h want 1 %0d %h",
                         ld_valid, ld_rob, ld_data, l.rob, l.data);
    end
  endtask

  task automatic test_bypass();
    cdb_valid = 2'b01; cdb_rob = {4'd0, 4'd7}; cdb_data = {32'h0, 32'h200};
    dispatch(1'b0, 6'h02, 4'd10, 32'd7, 1'b0, 32'h10, 32'h0, 1'b0);
    cdb_valid = 2'b00;
    exp_req.push_back('{1'b0, 6'h02, 32'h210, 32'h0});
    wait_req(ok);
    r = exp_req.pop_front(); checks++;
    if (!ok || mem_addr !== r.addr) begin
      errors++; $display("FAIL bypass_req: req=%b addr=%h want addr=%h", mem_req, mem_addr, r.addr);
    end
    exp_ld.push_back('{4'd10, 32'hCAFE});
    done_pulse(32'hCAFE);
    l = exp_ld.pop_front(); checks++;
    if (ld_valid !== 1'b1 || ld_rob !== l.rob || ld_data !== l.data) begin
      errors++; $display("FAIL bypass_ld: v=%b rob=%0d data=%h want 1 %0d %h",
                         ld_valid, ld_rob, ld_data, l.rob, l.data);
    end
  endtask

  task automatic test_cdb_priority();
    dispatch(1'b0, 6'h02, 4'd11, 32'd9, 1'b0, 32'h4, 32'h0, 1'b0);
    tick(); tick(); checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL prio_wait: req=%b want 0", mem_req); end
    cdb_valid = 2'b11; cdb_rob = {4'd9, 4'd9}; cdb_data = {32'h400, 32'h300};
    exp_req.push_back('{1'b0, 6'h02, 32'h304, 32'h0});
    tick();
    cdb_valid = 2'b00;
    wait_req(ok);
    r = exp_req.pop_front(); checks++;
    if (!ok || mem_addr !== r.addr) begin
      errors++; $display("FAIL prio_req: req=%b addr=%h want addr=%h", mem_req, mem_addr, r.addr);
    end
    done_pulse(32'h0);
  endtask

  task automatic test_rdy_freeze();
    dispatch(1'b0, 6'h02, 4'd9, 32'h6000, 1'b1, 32'h0, 32'h0, 1'b0);
    wait_req(ok);
    rdy = 1'b0; mem_done = 1'b1; mem_rdata = 32'h600D;
    tick(); tick(); checks++;
    if (!ok || ld_valid !== 1'b0 || count !== 5'd1 || mem_req !== 1'b1) begin
      errors++; $display("FAIL freeze_hold: ldv=%b count=%0d req=%b want 0 1 1", ld_valid, count, mem_req);
    end
    exp_ld.push_back('{4'd9, 32'h600D});
    rdy = 1'b1;
    tick();
    mem_done = 1'b0;
    l = exp_ld.pop_front(); checks++;
    if (ld_valid !== 1'b1 || ld_rob !== l.rob || ld_data !== l.data || count !== 5'd0) begin
      errors++; $display("FAIL freeze_release: v=%b rob=%0d data=%h count=%0d want 1 %0d %h 0",
                         ld_valid, ld_rob, ld_data, count, l.rob, l.data);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      dispatch(1'b0, 6'(k + 1), 4'(12 + k), 32'h7000 + 32'(k * 256), 1'b1, 32'h8, 32'h0, 1'b0);
      exp_req.push_back('{1'b0, 6'(k + 1), 32'h7008 + 32'(k * 256), 32'h0});
    end
    for (int k = 0; k < 3; k++) begin
      wait_req(ok);
      r = exp_req.pop_front(); checks++;
      if (!ok || mem_op !== r.op || mem_addr !== r.addr) begin
        errors++; $display("FAIL b2b_req%0d: req=%b op=%h addr=%h want op=%h addr=%h",
                           k, mem_req, mem_op, mem_addr, r.op, r.addr);
      end
      exp_ld.push_back('{4'(12 + k), 32'hA0 + 32'(k)});
      done_pulse(32'hA0 + 32'(k));
      l = exp_ld.pop_front(); checks++;
      if (ld_valid !== 1'b1 || ld_rob !== l.rob || ld_data !== l.data) begin
        errors++; $display("FAIL b2b_ld%0d: v=%b rob=%0d data=%h want 1 %0d %h",
                           k, ld_valid, ld_rob, ld_data, l.rob, l.data);
      end
    end
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL b2b_empty: count=%0d want 0", count); end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    is_valid = 1'b0; is_store = 1'b0; is_op = '0; is_rob = '0; is_base = '0;
    is_base_rdy = 1'b0; is_imm = '0; is_data = '0; is_data_rdy = 1'b0;
    cdb_valid = '0; cdb_rob = '0; cdb_data = '0;
    cm_valid = 1'b0; cm_rob = '0; flush = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    test_reset();
    test_load();
    test_store_commit();
    test_full_wrap();
    test_flush_commit();
    test_drain();
    test_bypass();
    test_cdb_priority();
    test_rdy_freeze();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsb_ring.md
Name: lsb_ring

Overview:
- Parametrised circular load/store buffer for the out-of-order RISC-V core, placed between issue, the ROB, the CDBs and the data-cache port.
- Holds memory ops in program order and snoops N result buses for base/store-data operands.
- Sends stores to memory only after ROB commit; sends loads as soon as they reach the head with a ready base.
- Broadcasts load results and supports a mispredict flush that preserves committed stores.

Parameters:
LSB_W, 4, log2 of entry count (DEPTH = 2^LSB_W)
ROB_W, 4, ROB tag width
CDB_N, 2, number of snooped result buses

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; when low, all state frozen
is_valid  in  1  dispatch one entry this cycle
is_store  in  1  1 = store, 0 = load
is_op  in  6  opcode, passed to memory
is_rob  in  ROB_W  ROB tag of the op
is_base  in  32  base value, or producer tag in [ROB_W-1:0] if not ready
is_base_rdy  in  1  base valid
is_imm  in  32  sign-extended offset
is_data  in  32  store data, or producer tag if not ready
is_data_rdy  in  1  store data valid (ignored for loads)
full  out  1  DEPTH entries occupied
count  out  LSB_W+1  occupancy
cdb_valid  in  CDB_N  per-bus valid
cdb_rob  in  CDB_N*ROB_W  per-bus tag, bus k at [k*ROB_W +: ROB_W]
cdb_data  in  CDB_N*32  per-bus result
cm_valid  in  1  ROB commits a store
cm_rob  in  ROB_W  tag of committed store
flush  in  1  mispredict: discard uncommitted entries
mem_req  out  1  request to data cache
mem_store  out  1  request is a store
mem_op  out  6  opcode of request
mem_addr  out  32  base+imm
mem_wdata  out  32  store data
mem_done  in  1  one-cycle completion from cache
mem_rdata  in  32  load data (valid with mem_done)
ld_valid  out  1  load result broadcast, 1 cycle
ld_rob  out  ROB_W  tag of load result
ld_data  out  32  load result

Behaviour:
- Reset (rst=1 at posedge, wins over everything):
  - head=tail=0, count=0, all entry valid/committed bits 0, drain=0.
  - mem_req=0, ld_valid=0; all other outputs 0.
- rdy=0: no state changes. mem_done is sampled only when rdy=1; the cache holds mem_done until it is sampled.
- Dispatch: is_valid && !full writes entry[tail], tail wraps modulo DEPTH, count+1. is_valid while full is a protocol error: entry dropped, no state change.
- Dispatch bypass: if a CDB bus in the same cycle matches a not-ready tag, the entry captures cdb_data as ready.
- CDB snoop: every valid entry with a not-ready base or data whose tag equals cdb_rob[k] with cdb_valid[k] captures the value and sets ready. If several buses match, the lowest k wins.
- Commit: cm_valid sets committed on the valid store entry whose rob equals cm_rob (CAM search). A commit with no match is ignored.
- Head issue FSM, states IDLE / BUSY / DRAIN:
  - IDLE -> BUSY when the head is valid and either:
    - load with base ready; or
    - store with base and data ready and committed.
  - On that transition, register mem_req=1, mem_addr=base+imm (mod 2^32), mem_wdata, mem_op, mem_store. Request appears the cycle after the condition is met.
  - BUSY: outputs held stable until mem_done.
  - BUSY + mem_done: mem_req=0, pop head, count-1.
    - If the popped entry is a load: next cycle ld_valid=1, ld_rob, ld_data=mem_rdata.
    - Return to IDLE. The next request can be issued no earlier than 1 cycle after mem_done.
  - DRAIN: an in-flight request was flushed. Wait for mem_done, swallow it (no ld_valid), go to IDLE.
- Flush:
  - All uncommitted entries are invalidated. Committed stores always form a prefix starting at head; tail = head + committed_count, and count is updated to match.
  - If BUSY on a load: head entry removed and state -> DRAIN.
  - If BUSY on a committed store: the store continues normally.
  - Dispatch, commit and CDB inputs in the flush cycle are ignored; a completing mem_done in that cycle is still honoured.
- Simultaneous dispatch and pop: count unchanged, full recomputed. Dispatch into a slot freed in the same cycle is not allowed, because full is evaluated before the pop.
- Wrap-around: pointers are LSB_W bits; full = (count == DEPTH).

Test Plan:
- Reset then dispatch load (rob=3, base=0x1000 ready, imm=-4) -> mem_req=1 next cycle, mem_addr=0x0FFC, mem_store=0. mem_done with rdata=0xDEADBEEF -> ld_valid=1, ld_rob=3, ld_data=0xDEADBEEF one cycle later; count back to 0.
- Store (rob=5) with data tag 2 not ready, base ready -> no mem_req. cdb_valid[1], cdb_rob=2, data=0x55 -> still no req. cm_valid, cm_rob=5 -> mem_req=1, mem_wdata=0x55.
- Fill DEPTH=16 entries -> full=1, count=16. 17th dispatch is dropped. Pop one -> full=0; tail wraps to index 0 on the next dispatch.
- Queue of committed store, uncommitted store, two loads; flush -> count=1, tail=head+1. The committed store still completes.
- Load in flight, flush -> state DRAIN, mem_req stays high until mem_done; no ld_valid is produced; the next request issues only afterwards.
- Dispatch with is_base_rdy=0, tag 7, same cycle as cdb_valid[0], cdb_rob=7, data=0x200 -> entry is ready; mem_req asserts the cycle after dispatch with mem_addr=0x200+imm.
